// File: rtl/tile_map_writer_if.sv
// Command and RAM write-port bundle for the tile map writer.
// The slave side is the writer engine; the master side is the CR16 I/O decode
// together with the RAM's second port.
interface tile_map_writer_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [6:0]        cmd_col;
   logic [5:0]        cmd_row;
   logic [DATA_W-1:0] cmd_data;
   logic [ADDR_W-1:0] raddr;
   logic [DATA_W-1:0] rdata;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              busy;
   logic              done;
   logic              err;

   modport slave (
      input  cmd_valid, cmd_op, cmd_col, cmd_row, cmd_data, rdata,
      output cmd_ready, raddr, we, waddr, wdata, busy, done, err
   );

   modport master (
      output cmd_valid, cmd_op, cmd_col, cmd_row, cmd_data, rdata,
      input  cmd_ready, raddr, we, waddr, wdata, busy, done, err
   );
endinterface

// File: rtl/tile_map_writer.sv
// Write-side engine for the 80x60 tile display RAM. Turns single commands
// (write cell, fill screen, scroll up one row) into sequenced RAM cycles.
// All RAM-side outputs are decoded from registered state, so the first RAM
// action of a command appears in the cycle after acceptance.
module tile_map_writer #(
   parameter int COLS   = 80,
   parameter int ROWS   = 60,
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              clr,
   tile_map_writer_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CELL,
      S_FILL,
      S_SCR_RD,
      S_SCR_WR,
      S_SCR_FILL,
      S_ERR
   } state_t;

   localparam logic [ADDR_W-1:0] COLS_A      = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] LAST_A      = ADDR_W'(COLS * ROWS - 1);
   localparam logic [ADDR_W-1:0] COPY_LAST_A = ADDR_W'((ROWS - 1) * COLS - 1);
   localparam logic [6:0]        COLS_C      = 7'(COLS);
   localparam logic [5:0]        ROWS_C      = 6'(ROWS);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;   // write address / scroll copy index
   logic [DATA_W-1:0] data_q,  data_d;   // latched cmd_data
   logic [ADDR_W-1:0] raddr_q, raddr_d;  // read address, held outside SCR_RD

   logic [ADDR_W-1:0] cell_addr;
   logic              cell_ok;

   assign cell_addr = ADDR_W'(bus.cmd_row) * COLS_A + ADDR_W'(bus.cmd_col);
   assign cell_ok   = (bus.cmd_col < COLS_C) && (bus.cmd_row < ROWS_C);

   // State and datapath registers; clr returns everything to a clean IDLE.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         raddr_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         raddr_q <= raddr_d;
      end
   end

   // Next-state logic and RAM/handshake outputs decoded from current state.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      data_d        = data_q;
      raddr_d       = raddr_q;
      bus.raddr     = raddr_q;
      bus.we        = 1'b0;
      bus.waddr     = addr_q;
      bus.wdata     = data_q;
      bus.done      = 1'b0;
      bus.err       = 1'b0;
      bus.cmd_ready = (state_q == S_IDLE);
      bus.busy      = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               data_d = bus.cmd_data;
               case (bus.cmd_op)
                  2'b00: begin
                     if (cell_ok) begin
                        state_d = S_CELL;
                        addr_d  = cell_addr;
                     end else begin
                        state_d = S_ERR;
                     end
                  end
                  2'b01: begin
                     state_d = S_FILL;
                     addr_d  = '0;
                  end
                  2'b10: begin
                     state_d = S_SCR_RD;
                     addr_d  = '0;
                  end
                  default: state_d = S_ERR;
               endcase
            end
         end

         S_CELL: begin
            bus.we   = 1'b1;
            bus.done = 1'b1;
            state_d  = S_IDLE;
         end

         S_FILL: begin
            bus.we = 1'b1;
            if (addr_q == LAST_A) begin
               bus.done = 1'b1;
               state_d  = S_IDLE;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end

         S_SCR_RD: begin
            // Source cell sits one row below the destination.
            bus.raddr = addr_q + COLS_A;
            raddr_d   = addr_q + COLS_A;
            state_d   = S_SCR_WR;
         end

         S_SCR_WR: begin
            bus.we    = 1'b1;
            bus.wdata = bus.rdata;
            addr_d    = addr_q + 1'b1;
            state_d   = (addr_q == COPY_LAST_A) ? S_SCR_FILL : S_SCR_RD;
         end

         S_SCR_FILL: begin
            bus.we = 1'b1;
            if (addr_q == LAST_A) begin
               bus.done = 1'b1;
               state_d  = S_IDLE;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end

         S_ERR: begin
            bus.err = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule
